// File: rtl/pc_attack_engine_if.sv
// Handshake and board/map bundle between the game controller side and the PC attack engine.
interface pc_attack_engine_if #(
  parameter int N = 5
);
  localparam int CELLS = N * N;
  localparam int IW    = $clog2(CELLS);
  localparam int CW    = $clog2(CELLS + 1);

  logic             new_game;
  logic             pc_turn;
  logic [CELLS-1:0] player_board;
  logic             pc_move;
  logic             shot_valid;
  logic             shot_hit;
  logic [IW-1:0]    shot_idx;
  logic [IW-1:0]    shot_row;
  logic [IW-1:0]    shot_col;
  logic [CELLS-1:0] shot_map;
  logic [CELLS-1:0] hit_map;
  logic [CW-1:0]    cells_left;
  logic             busy;

  modport master (
    output new_game, pc_turn, player_board,
    input  pc_move, shot_valid, shot_hit, shot_idx, shot_row, shot_col,
           shot_map, hit_map, cells_left, busy
  );

  modport slave (
    input  new_game, pc_turn, player_board,
    output pc_move, shot_valid, shot_hit, shot_idx, shot_row, shot_col,
           shot_map, hit_map, cells_left, busy
  );
endinterface

// File: rtl/pc_attack_engine.sv
// Computer-opponent shot generator: picks an unattacked player cell per PC turn via an LFSR
// plus linear probe, resolves hit/miss and maintains shot/hit maps and remaining ship cells.
module pc_attack_engine #(
  parameter int         N         = 5,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input logic              clk,
  input logic              rst,
  pc_attack_engine_if.slave bus
);
  localparam int CELLS = N * N;
  localparam int IW    = $clog2(CELLS);
  localparam int CW    = $clog2(CELLS + 1);

  typedef enum logic [2:0] {IDLE, LOAD, SCAN, FIRE, DONE} state_e;

  state_e           state_q, state_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic             pc_turn_q, pc_turn_d;
  logic [IW-1:0]    cand_q, cand_d;
  logic [CELLS-1:0] shot_map_q, shot_map_d;
  logic [CELLS-1:0] hit_map_q, hit_map_d;
  logic [IW-1:0]    shot_idx_q, shot_idx_d;
  logic             shot_valid_q, shot_valid_d;
  logic             shot_hit_q, shot_hit_d;
  logic [CW-1:0]    cells_left_q, cells_left_d;
  logic [CW-1:0]    shot_count_q, shot_count_d;

  logic             start;
  logic [IW-1:0]    raw_cand;
  logic [IW-1:0]    cand_load;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] c);
    return (c == IW'(CELLS - 1)) ? '0 : c + 1'b1;
  endfunction

  assign start    = bus.pc_turn & ~pc_turn_q;
  assign raw_cand = lfsr_q[IW-1:0];
  assign cand_load = (int'(raw_cand) >= CELLS) ? raw_cand - IW'(CELLS) : raw_cand;

  always_comb begin
    state_d      = state_q;
    lfsr_d       = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
    pc_turn_d    = bus.pc_turn;
    cand_d       = cand_q;
    shot_map_d   = shot_map_q;
    hit_map_d    = hit_map_q;
    shot_idx_d   = shot_idx_q;
    shot_valid_d = shot_valid_q;
    shot_hit_d   = shot_hit_q;
    cells_left_d = cells_left_q;
    shot_count_d = shot_count_q;

    if (bus.new_game) begin
      state_d      = IDLE;
      shot_map_d   = '0;
      hit_map_d    = '0;
      shot_idx_d   = '0;
      shot_valid_d = 1'b0;
      shot_hit_d   = 1'b0;
      shot_count_d = '0;
      cells_left_d = CW'($countones(bus.player_board));
    end else begin
      unique case (state_q)
        IDLE: if (start) state_d = LOAD;
        // The first candidate is probed here, so a free landing cell goes straight to FIRE.
        LOAD: begin
          if (shot_count_q == CW'(CELLS)) begin
            shot_valid_d = 1'b0;
            state_d      = DONE;
          end else if (shot_map_q[cand_load]) begin
            cand_d  = next_idx(cand_load);
            state_d = SCAN;
          end else begin
            cand_d  = cand_load;
            state_d = FIRE;
          end
        end
        SCAN: begin
          if (shot_map_q[cand_q]) cand_d = next_idx(cand_q);
          else                    state_d = FIRE;
        end
        FIRE: begin
          shot_map_d[cand_q] = 1'b1;
          shot_idx_d         = cand_q;
          shot_valid_d       = 1'b1;
          shot_hit_d         = bus.player_board[cand_q];
          shot_count_d       = shot_count_q + 1'b1;
          if (bus.player_board[cand_q]) begin
            hit_map_d[cand_q] = 1'b1;
            if (cells_left_q != '0) cells_left_d = cells_left_q - 1'b1;
          end
          state_d = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      lfsr_q       <= LFSR_SEED;
      pc_turn_q    <= 1'b0;
      cand_q       <= '0;
      shot_map_q   <= '0;
      hit_map_q    <= '0;
      shot_idx_q   <= '0;
      shot_valid_q <= 1'b0;
      shot_hit_q   <= 1'b0;
      cells_left_q <= '0;
      shot_count_q <= '0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      pc_turn_q    <= pc_turn_d;
      cand_q       <= cand_d;
      shot_map_q   <= shot_map_d;
      hit_map_q    <= hit_map_d;
      shot_idx_q   <= shot_idx_d;
      shot_valid_q <= shot_valid_d;
      shot_hit_q   <= shot_hit_d;
      cells_left_q <= cells_left_d;
      shot_count_q <= shot_count_d;
    end
  end

  assign bus.pc_move    = (state_q == DONE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.shot_valid = shot_valid_q;
  assign bus.shot_hit   = shot_hit_q;
  assign bus.shot_idx   = shot_idx_q;
  assign bus.shot_row   = IW'(int'(shot_idx_q) / N);
  assign bus.shot_col   = IW'(int'(shot_idx_q) % N);
  assign bus.shot_map   = shot_map_q;
  assign bus.hit_map    = hit_map_q;
  assign bus.cells_left = cells_left_q;
endmodule
